// File: rtl/riscv_pmp_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_pmp_arbiter
//   Shares one combinational PMP checker between the instruction-fetch port and
//   the data-memory port. A request is accepted in IDLE/RESP, checked in CHECK
//   (fault sampled at the end of the cycle), and its result strobed in RESP.
//   Accept at cycle N gives a response at cycle N+2.
//
//   Arbitration (build option, macro RISCV_PMP_ARB_RR_EN):
//     undefined : data wins ties; after STARVE_MAX consecutive data grants with
//                 a pending fetch, the fetch wins once.
//     defined   : round-robin between the two ports; STARVE_MAX is ignored.
//
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   if_req_i/adr/size           fetch check request
//   if_ack_o                    fetch request accepted this cycle
//   if_rsp_valid_o/exception_o  fetch result strobe and PMP fault
//   dm_req_i/adr/size/we        data check request
//   dm_ack_o                    data request accepted this cycle
//   dm_rsp_valid_o/exception_o  data result strobe and PMP fault
//   flush_i                     pipeline flush (cancels fetch-side work only)
//   pmp_upd_i                   pmpcfg/pmpaddr CSR write this cycle
//   chk_*_o                     access presented to the shared checker
//   chk_exception_i             checker fault for the chk_* access
// -----------------------------------------------------------------------------
module riscv_pmp_arbiter #(
  parameter int PLEN       = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rstn,

  input  logic            if_req_i,
  input  logic [PLEN-1:0] if_adr_i,
  input  logic [2:0]      if_size_i,
  output logic            if_ack_o,
  output logic            if_rsp_valid_o,
  output logic            if_exception_o,

  input  logic            dm_req_i,
  input  logic [PLEN-1:0] dm_adr_i,
  input  logic [2:0]      dm_size_i,
  input  logic            dm_we_i,
  output logic            dm_ack_o,
  output logic            dm_rsp_valid_o,
  output logic            dm_exception_o,

  input  logic            flush_i,
  input  logic            pmp_upd_i,

  output logic            chk_req_o,
  output logic            chk_instruction_o,
  output logic [PLEN-1:0] chk_adr_o,
  output logic [2:0]      chk_size_o,
  output logic            chk_we_o,
  input  logic            chk_exception_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            instr_q, instr_d;
  logic [PLEN-1:0] adr_q,   adr_d;
  logic [2:0]      size_q,  size_d;
  logic            we_q,    we_d;
  logic            exc_q,   exc_d;

`ifdef RISCV_PMP_ARB_RR_EN
  // Set after a data grant: the fetch port has priority on the next tie.
  logic            rr_if_pri_q, rr_if_pri_d;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0]      starve_q, starve_d;
`endif

  logic accept_ok;
  logic i_cand;
  logic d_cand;
  logic i_wins;
  logic grant_i;
  logic grant_d;

  // Grant selection. Acks are qualified with rstn so every output is low while
  // reset is held, even with requests pending.
  always_comb begin
    accept_ok = rstn && ((state_q == IDLE) || (state_q == RESP)) && !pmp_upd_i;
    i_cand    = if_req_i && !flush_i;
    d_cand    = dm_req_i;
`ifdef RISCV_PMP_ARB_RR_EN
    i_wins    = i_cand && (!d_cand || rr_if_pri_q);
`else
    i_wins    = i_cand && (!d_cand || (starve_q == STARVE_LIM));
`endif
    grant_i   = accept_ok && i_wins;
    grant_d   = accept_ok && d_cand && !i_wins;
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    adr_d   = adr_q;
    size_d  = size_q;
    we_d    = we_q;
    exc_d   = exc_q;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (grant_i || grant_d) begin
          state_d = CHECK;
          instr_d = grant_i;
          adr_d   = grant_i ? if_adr_i  : dm_adr_i;
          size_d  = grant_i ? if_size_i : dm_size_i;
          we_d    = grant_i ? 1'b0      : dm_we_i;
        end
      end
      CHECK: begin
        // Flush of a fetch check outranks a concurrent CSR update.
        if (instr_q && flush_i) begin
          state_d = IDLE;
        end else if (pmp_upd_i) begin
          state_d = CHECK;
        end else begin
          exc_d   = chk_exception_i;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RISCV_PMP_ARB_RR_EN
  always_comb begin
    rr_if_pri_d = rr_if_pri_q;
    if (grant_d) rr_if_pri_d = 1'b1;
    if (grant_i) rr_if_pri_d = 1'b0;
  end
`else
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || grant_i) begin
      starve_d = '0;
    end else if (grant_d && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      instr_q     <= 1'b0;
      adr_q       <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      exc_q       <= 1'b0;
`ifdef RISCV_PMP_ARB_RR_EN
      rr_if_pri_q <= 1'b0;
`else
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      adr_q       <= adr_d;
      size_q      <= size_d;
      we_q        <= we_d;
      exc_q       <= exc_d;
`ifdef RISCV_PMP_ARB_RR_EN
      rr_if_pri_q <= rr_if_pri_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign if_ack_o          = grant_i;
  assign dm_ack_o          = grant_d;

  // A flush arriving during the fetch response cycle suppresses the strobe.
  assign if_rsp_valid_o    = (state_q == RESP) && instr_q && !flush_i;
  assign dm_rsp_valid_o    = (state_q == RESP) && !instr_q;
  assign if_exception_o    = if_rsp_valid_o && exc_q;
  assign dm_exception_o    = dm_rsp_valid_o && exc_q;

  assign chk_req_o         = (state_q == CHECK);
  assign chk_instruction_o = instr_q;
  assign chk_adr_o         = adr_q;
  assign chk_size_o        = size_q;
  assign chk_we_o          = we_q;

endmodule
